// File: rtl/cache_config_pkg.sv
// -----------------------------------------------------------------------------
// cache_config_pkg
// Shared definitions for the last-level cache snoop responder:
//   - address field widths (tag / set index / block offset) and associativity
//   - MESI, snoop-result, bus-operation and L1-message encodings
//   - responder FSM state encoding
//   - snoop_decide(): the MESI snoop transition table as a pure function
// -----------------------------------------------------------------------------
package cache_config_pkg;

   localparam int ADDR_BITS   = 32;
   localparam int TAG_BITS    = 12;   // addr[31:20]
   localparam int INDEX_BITS  = 14;   // addr[19:6]
   localparam int OFFSET_BITS = 6;    // addr[5:0]
   localparam int WAYS        = 16;
   localparam int WAY_BITS    = 4;
   localparam int SETS        = 1 << INDEX_BITS;

   typedef enum logic [1:0] {
      MESI_I = 2'd0,
      MESI_S = 2'd1,
      MESI_E = 2'd2,
      MESI_M = 2'd3
   } mesi_t;

   typedef enum logic [1:0] {
      SNOOP_NOHIT = 2'd0,
      SNOOP_HIT   = 2'd1,
      SNOOP_HITM  = 2'd2
   } snoop_result_t;

   typedef enum logic [1:0] {
      BUS_READ       = 2'd0,
      BUS_WRITE      = 2'd1,
      BUS_INVALIDATE = 2'd2,
      BUS_RWIM       = 2'd3
   } bus_op_t;

   typedef enum logic [1:0] {
      MSG_GETLINE        = 2'd0,
      MSG_SENDLINE       = 2'd1,
      MSG_INVALIDATELINE = 2'd2,
      MSG_EVICTLINE      = 2'd3
   } l1_msg_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_RESP   = 2'd2,
      ST_WB     = 2'd3
   } fsm_t;

   // Everything the responder does for one snooped operation.
   typedef struct packed {
      snoop_result_t result;
      logic          msg_valid;
      l1_msg_t       msg;
      logic          writeback;   // line is modified: flush before finishing
      logic          dir_write;   // directory entry changes state
      mesi_t         new_state;
   } snoop_action_t;

   // MESI snoop transition table. 'hit' already implies st != I.
   function automatic snoop_action_t snoop_decide(bus_op_t op, logic hit, mesi_t st);
      snoop_action_t act;
      act.result    = SNOOP_NOHIT;
      act.msg_valid = 1'b0;
      act.msg       = MSG_GETLINE;
      act.writeback = 1'b0;
      act.dir_write = 1'b0;
      act.new_state = st;
      if (hit) begin
         unique case (op)
            BUS_READ: begin
               act.result = SNOOP_HIT;
               if (st == MESI_E) begin
                  act.dir_write = 1'b1;
                  act.new_state = MESI_S;
               end else if (st == MESI_M) begin
                  act.result    = SNOOP_HITM;
                  act.msg_valid = 1'b1;
                  act.msg       = MSG_GETLINE;
                  act.writeback = 1'b1;
                  act.dir_write = 1'b1;
                  act.new_state = MESI_S;
               end
            end
            BUS_WRITE: begin
               // Another cache writing back its own line: never ours to answer.
            end
            BUS_INVALIDATE: begin
               // Only a sharer may see INVALIDATE; E/M here is a protocol error
               // and is answered NOHIT without touching the entry.
               if (st == MESI_S) begin
                  act.result    = SNOOP_HIT;
                  act.msg_valid = 1'b1;
                  act.msg       = MSG_INVALIDATELINE;
                  act.dir_write = 1'b1;
                  act.new_state = MESI_I;
               end
            end
            BUS_RWIM: begin
               act.msg_valid = 1'b1;
               act.dir_write = 1'b1;
               act.new_state = MESI_I;
               if (st == MESI_M) begin
                  act.result    = SNOOP_HITM;
                  act.msg       = MSG_EVICTLINE;
                  act.writeback = 1'b1;
               end else begin
                  act.result    = SNOOP_HIT;
                  act.msg       = MSG_INVALIDATELINE;
               end
            end
            default: ;
         endcase
      end
      return act;
   endfunction

endpackage

// File: rtl/llc_snoop_responder_dir.sv
// -----------------------------------------------------------------------------
// llc_snoop_dir
// MESI tag directory for the last-level cache (SETS x WAYS entries).
//   clk, rst_n          clock, synchronous active-low reset (all entries -> I)
//   i_rd_en             register a lookup of i_rd_index / i_rd_tag this edge
//   o_hit/o_way/o_state registered lookup result (lowest matching way wins)
//   i_snp_*             snoop state update (state only, tag unchanged)
//   i_upd_*             local install/change of an entry (tag + state)
//   o_upd_ready         upd accepted this edge; low on snoop-update edges
// -----------------------------------------------------------------------------
module llc_snoop_dir
   import cache_config_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_rd_en,
   input  logic [INDEX_BITS-1:0] i_rd_index,
   input  logic [TAG_BITS-1:0]   i_rd_tag,
   output logic                  o_hit,
   output logic [WAY_BITS-1:0]   o_way,
   output mesi_t                 o_state,
   input  logic                  i_snp_we,
   input  logic [INDEX_BITS-1:0] i_snp_index,
   input  logic [WAY_BITS-1:0]   i_snp_way,
   input  mesi_t                 i_snp_state,
   input  logic                  i_upd_valid,
   input  logic [INDEX_BITS-1:0] i_upd_index,
   input  logic [WAY_BITS-1:0]   i_upd_way,
   input  logic [TAG_BITS-1:0]   i_upd_tag,
   input  logic [1:0]            i_upd_state,
   output logic                  o_upd_ready
);

   mesi_t               r_state [SETS][WAYS];
   logic [TAG_BITS-1:0] r_tag   [SETS][WAYS];

   logic                w_hit;
   logic [WAY_BITS-1:0] w_way;
   mesi_t               w_state;
   logic                w_upd_we;

   // Snoop updates win the single write port; the local cache holds upd.
   assign o_upd_ready = rst_n && !i_snp_we;
   assign w_upd_we    = i_upd_valid && o_upd_ready;

   // Tag compare across the set. Scanning downward lets the lowest matching
   // way overwrite any higher one.
   always_comb begin
      // NOTE: every variable gets a default before any conditional assignment,
      // so no path leaves it unassigned and no latch is inferred.
      w_hit   = 1'b0;
      w_way   = '0;
      w_state = MESI_I;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (r_state[i_rd_index][w] != MESI_I && r_tag[i_rd_index][w] == i_rd_tag) begin
            w_hit   = 1'b1;
            w_way   = WAY_BITS'(w);
            w_state = r_state[i_rd_index][w];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         o_hit   <= 1'b0;
         o_way   <= '0;
         o_state <= MESI_I;
      end else if (i_rd_en) begin
         o_hit   <= w_hit;
         o_way   <= w_way;
         o_state <= w_state;
      end
   end

   // State array is cleared by reset: an I entry is what makes a tag invalid.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               r_state[s][w] <= MESI_I;
            end
         end
      end else if (i_snp_we) begin
         r_state[i_snp_index][i_snp_way] <= i_snp_state;
      end else if (w_upd_we) begin
         r_state[i_upd_index][i_upd_way] <= mesi_t'(i_upd_state);
      end
   end

   // NOTE: the tag array has no reset; a stale tag is harmless because its
   // state entry is I after reset, so it is plain storage rather than flops.
   always_ff @(posedge clk) begin
      if (w_upd_we) begin
         r_tag[i_upd_index][i_upd_way] <= i_upd_tag;
      end
   end

endmodule

// File: rtl/llc_snoop_responder.sv
// -----------------------------------------------------------------------------
// llc_snoop_responder
// Bus-side snoop responder of the shared last-level cache.
//   clk, rst_n                 clock, synchronous active-low reset
//   bus_valid/bus_ready        snooped bus op handshake (ready in IDLE only)
//   bus_op, bus_addr           op and address, sampled at the accept edge
//   snoop_valid, snoop_result  one-cycle NOHIT/HIT/HITM strobe, 2 edges after accept
//   msg_valid, msg, msg_addr   one-cycle L1 notification, aligned with snoop_valid
//   wb_valid/wb_ready, wb_addr writeback of a modified line, held until accepted
//   upd_*                      local directory installs (tag/state per set/way)
// Flow: IDLE -> LOOKUP -> RESP -> (HITM ? WB : IDLE).
// -----------------------------------------------------------------------------
module llc_snoop_responder
   import cache_config_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  bus_valid,
   output logic                  bus_ready,
   input  logic [1:0]            bus_op,
   input  logic [ADDR_BITS-1:0]  bus_addr,
   output logic                  snoop_valid,
   output logic [1:0]            snoop_result,
   output logic                  msg_valid,
   output logic [1:0]            msg,
   output logic [ADDR_BITS-1:0]  msg_addr,
   output logic                  wb_valid,
   input  logic                  wb_ready,
   output logic [ADDR_BITS-1:0]  wb_addr,
   input  logic                  upd_valid,
   output logic                  upd_ready,
   input  logic [INDEX_BITS-1:0] upd_index,
   input  logic [WAY_BITS-1:0]   upd_way,
   input  logic [TAG_BITS-1:0]   upd_tag,
   input  logic [1:0]            upd_state
);

   fsm_t                 r_fsm;
   fsm_t                 w_fsm_nxt;
   bus_op_t              r_op;
   logic [ADDR_BITS-1:0] r_addr;

   logic                  w_accept;
   logic                  w_rd_en;
   logic                  w_snp_we;
   logic                  w_dir_hit;
   logic [WAY_BITS-1:0]   w_dir_way;
   mesi_t                 w_dir_state;
   snoop_action_t         w_act;
   logic [ADDR_BITS-1:0]  w_line_addr;
   logic [INDEX_BITS-1:0] w_index;
   logic [TAG_BITS-1:0]   w_tag;

   assign bus_ready   = rst_n && (r_fsm == ST_IDLE);
   assign w_accept    = bus_valid && bus_ready;
   assign w_index     = r_addr[OFFSET_BITS +: INDEX_BITS];
   assign w_tag       = r_addr[ADDR_BITS-1 -: TAG_BITS];
   assign w_line_addr = {r_addr[ADDR_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

   // The directory result is frozen at the end of LOOKUP, so the action stays
   // stable through RESP and WB even if the local cache rewrites the entry.
   assign w_act    = snoop_decide(r_op, w_dir_hit, w_dir_state);
   assign msg_addr = w_line_addr;
   assign wb_addr  = w_line_addr;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      if (!rst_n) begin
         r_fsm  <= ST_IDLE;
         r_op   <= BUS_READ;
         r_addr <= '0;
      end else begin
         r_fsm <= w_fsm_nxt;
         if (w_accept) begin
            r_op   <= bus_op_t'(bus_op);
            r_addr <= bus_addr;
         end
      end
   end

   always_comb begin
      w_fsm_nxt    = r_fsm;
      w_rd_en      = 1'b0;
      w_snp_we     = 1'b0;
      snoop_valid  = 1'b0;
      snoop_result = SNOOP_NOHIT;
      msg_valid    = 1'b0;
      msg          = MSG_GETLINE;
      wb_valid     = 1'b0;
      unique case (r_fsm)
         ST_IDLE: begin
            if (w_accept) w_fsm_nxt = ST_LOOKUP;
         end
         ST_LOOKUP: begin
            w_rd_en   = 1'b1;
            w_fsm_nxt = ST_RESP;
         end
         ST_RESP: begin
            snoop_valid  = 1'b1;
            snoop_result = w_act.result;
            msg_valid    = w_act.msg_valid;
            msg          = w_act.msg;
            if (w_act.writeback) begin
               w_fsm_nxt = ST_WB;
            end else begin
               w_snp_we  = w_act.dir_write;
               w_fsm_nxt = ST_IDLE;
            end
         end
         ST_WB: begin
            // A modified line keeps its state until memory takes the data.
            wb_valid = 1'b1;
            if (wb_ready) begin
               w_snp_we  = w_act.dir_write;
               w_fsm_nxt = ST_IDLE;
            end
         end
         default: w_fsm_nxt = ST_IDLE;
      endcase
   end

   llc_snoop_dir u_dir (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_rd_en     (w_rd_en),
      .i_rd_index  (w_index),
      .i_rd_tag    (w_tag),
      .o_hit       (w_dir_hit),
      .o_way       (w_dir_way),
      .o_state     (w_dir_state),
      .i_snp_we    (w_snp_we),
      .i_snp_index (w_index),
      .i_snp_way   (w_dir_way),
      .i_snp_state (w_act.new_state),
      .i_upd_valid (upd_valid),
      .i_upd_index (upd_index),
      .i_upd_way   (upd_way),
      .i_upd_tag   (upd_tag),
      .i_upd_state (upd_state),
      .o_upd_ready (upd_ready)
   );

endmodule
